// File: rtl/dkong_scandoubler.sv
// Line-doubling scan converter: 15 kHz arcade video in, 31 kHz video out.
// Each accepted input line is captured into one half of a ping-pong line
// buffer while the previous line is replayed twice at double pixel rate.
module dkong_scandoubler #(
  parameter int ADDR_W   = 9,
  parameter int PIX_DIV  = 4,
  parameter int OUT_HS_W = 46,
  parameter int MIN_LINE = 16
) (
  input  logic              I_CLK_24576M,
  input  logic              I_RESET,
  input  logic              I_PIX_CE,
  input  logic [3:0]        I_R,
  input  logic [3:0]        I_G,
  input  logic [3:0]        I_B,
  input  logic              I_HBLANK,
  input  logic              I_VBLANK,
  input  logic              I_HSYNCn,
  input  logic              I_VSYNCn,
  output logic              O_PIX_CE,
  output logic [3:0]        O_R,
  output logic [3:0]        O_G,
  output logic [3:0]        O_B,
  output logic              O_HBLANK,
  output logic              O_VBLANK,
  output logic              O_HSYNCn,
  output logic              O_VSYNCn,
  output logic [ADDR_W:0]   O_LINE_LEN
);

  localparam int HALF  = PIX_DIV / 2;
  localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DEPTH = 2 ** (ADDR_W + 1);

  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] MIN_L   = (ADDR_W + 1)'(MIN_LINE);
  localparam logic [ADDR_W:0] HS_W_L  = (ADDR_W + 1)'(OUT_HS_W);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE,
    PASS0,
    PASS1
  } rd_state_t;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [12:0]       mem [0:DEPTH-1];

  logic              hs_d;
  logic              hs_fall;
  logic [ADDR_W:0]   wptr;
  logic              sat;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wcnt_next;
  logic              accept;
  logic              wbank;
  logic              valid;
  logic [ADDR_W:0]   line_len;
  logic              vs_lat;
  logic              vb_lat;

  rd_state_t         state;
  logic [ADDR_W-1:0] hcnt;
  logic [PH_W-1:0]   phase;
  logic              tick;
  logic              last;

  logic [12:0]       rd_q;
  logic              p1_ce;
  logic              p1_act;
  logic              p1_hs;
  logic              p1_vs;
  logic              p1_vb;

  // Write-side combinational helpers: the pixel coinciding with the hsync
  // fall is included in the length used for the accept decision.
  always_comb begin
    hs_fall   = hs_d & ~I_HSYNCn;
    sat       = wptr[ADDR_W];
    waddr     = sat ? '1 : wptr[ADDR_W-1:0];
    wcnt_next = wptr + ((I_PIX_CE && !sat) ? ONE : '0);
    accept    = hs_fall && (wcnt_next >= MIN_L);
    tick      = (state != IDLE) && (phase == '0);
    last      = ({1'b0, hcnt} == (line_len - ONE));
  end

  assign O_LINE_LEN = line_len;

  // Line-buffer write port; contents are intentionally not reset.
  always_ff @(posedge I_CLK_24576M) begin
    if (I_PIX_CE)
      mem[{wbank, waddr}] <= {I_HBLANK, I_R, I_G, I_B};
  end

  // Write pointer, line-boundary detection and bank swap.
  always_ff @(posedge I_CLK_24576M) begin
    if (I_RESET) begin
      hs_d     <= 1'b1;
      wptr     <= '0;
      wbank    <= 1'b0;
      valid    <= 1'b0;
      line_len <= '0;
      vs_lat   <= 1'b1;
      vb_lat   <= 1'b1;
    end else begin
      hs_d <= I_HSYNCn;
      if (hs_fall) begin
        wptr <= '0;
        if (accept) begin
          line_len <= wcnt_next;
          wbank    <= ~wbank;
          valid    <= 1'b1;
          vs_lat   <= I_VSYNCn;
          vb_lat   <= I_VBLANK;
        end
      end else begin
        wptr <= wcnt_next;
      end
    end
  end

  // Read-side sequencer: two passes over the read bank per accepted line.
  always_ff @(posedge I_CLK_24576M) begin
    if (I_RESET) begin
      state <= IDLE;
      hcnt  <= '0;
      phase <= '0;
    end else if (accept) begin
      state <= PASS0;
      hcnt  <= '0;
      phase <= '0;
    end else if (state != IDLE) begin
      phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      if (tick) begin
        if (last) begin
          hcnt  <= '0;
          state <= (state == PASS0) ? PASS1 : IDLE;
        end else begin
          hcnt <= hcnt + ADDR_W'(1);
        end
      end
    end
  end

  // Synchronous read of the bank not being written.
  always_ff @(posedge I_CLK_24576M) begin
    rd_q <= mem[{~wbank, hcnt}];
  end

  // First pipeline stage: timing/sync information aligned with the RAM read.
  always_ff @(posedge I_CLK_24576M) begin
    if (I_RESET) begin
      p1_ce  <= 1'b0;
      p1_act <= 1'b0;
      p1_hs  <= 1'b0;
      p1_vs  <= 1'b1;
      p1_vb  <= 1'b1;
    end else begin
      p1_ce  <= tick;
      p1_act <= valid && (state != IDLE);
      p1_hs  <= ({1'b0, hcnt} < HS_W_L);
      p1_vs  <= vs_lat;
      p1_vb  <= vb_lat;
    end
  end

  // Output register; idle or invalid buffer forces black with blanking.
  always_ff @(posedge I_CLK_24576M) begin
    if (I_RESET) begin
      O_PIX_CE <= 1'b0;
      O_R      <= '0;
      O_G      <= '0;
      O_B      <= '0;
      O_HBLANK <= 1'b1;
      O_HSYNCn <= 1'b1;
      O_VSYNCn <= 1'b1;
      O_VBLANK <= 1'b1;
    end else begin
      O_PIX_CE <= p1_ce && p1_act;
      O_VSYNCn <= p1_vs;
      O_VBLANK <= p1_vb;
      if (!p1_act) begin
        O_R      <= '0;
        O_G      <= '0;
        O_B      <= '0;
        O_HBLANK <= 1'b1;
        O_HSYNCn <= 1'b1;
      end else if (p1_ce) begin
        {O_HBLANK, O_R, O_G, O_B} <= rd_q;
        O_HSYNCn                  <= ~p1_hs;
      end
    end
  end

endmodule

// File: tb/tb_dkong_scandoubler.sv
// Directed bench for dkong_scandoubler: drives whole input lines and checks
// every output pixel against the line it should replay.
module tb_dkong_scandoubler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [3:0]  r, g, b;
  logic        hblank, vblank, hsyncn, vsyncn;
  logic        o_ce;
  logic [3:0]  o_r, o_g, o_b;
  logic        o_hblank, o_vblank, o_hsyncn, o_vsyncn;
  logic [9:0]  o_len;

  dkong_scandoubler #(
    .ADDR_W  (9),
    .PIX_DIV (4),
    .OUT_HS_W(46),
    .MIN_LINE(16)
  ) dut (
    .I_CLK_24576M(clk),
    .I_RESET     (rst),
    .I_PIX_CE    (pix_ce),
    .I_R         (r),
    .I_G         (g),
    .I_B         (b),
    .I_HBLANK    (hblank),
    .I_VBLANK    (vblank),
    .I_HSYNCn    (hsyncn),
    .I_VSYNCn    (vsyncn),
    .O_PIX_CE    (o_ce),
    .O_R         (o_r),
    .O_G         (o_g),
    .O_B         (o_b),
    .O_HBLANK    (o_hblank),
    .O_VBLANK    (o_vblank),
    .O_HSYNCn    (o_hsyncn),
    .O_VSYNCn    (o_vsyncn),
    .O_LINE_LEN  (o_len)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int col;
    int syn;
  } pulse_t;
  pulse_t pq[$];

  // Record every output pixel pulse away from the active edge.
  always @(negedge clk) begin
    if (o_ce === 1'b1) begin
      pulse_t p;
      p.cyc = cyc;
      p.col = int'({o_hblank, o_r, o_g, o_b});
      p.syn = int'({o_hsyncn, o_vsyncn, o_vblank});
      pq.push_back(p);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int s[0:6];
  int rst_cyc;
  int lens[0:6] = '{384, 384, 384, 374, 512, 384, 183};
  bit vs_l[0:6] = '{1, 0, 1, 1, 1, 1, 1};
  bit vb_l[0:6] = '{0, 0, 1, 0, 0, 0, 0};

  function automatic int colour(input int i);
    logic [11:0] v;
    v = 12'(i);
    return ((i >= 320) ? 4096 : 0) + (int'(v[3:0]) << 8) + (int'(v[7:4]) << 4) + int'(v[11:8]);
  endfunction

  // Input pixel index held in buffer entry e of line k.
  function automatic int exp_pix(input int k, input int e);
    if (k == 3) return e + 10;
    if (k == 6) return e + 201;
    if (k == 4 && e == 511) return 599;
    return e;
  endfunction

  task automatic run_line(input int npix, input int glitch_at, input int rst_at,
                          input bit vs, input bit vb, input int prev_len,
                          output int swap_cyc);
    vsyncn = vs;
    vblank = vb;
    for (int i = 0; i < npix; i++) begin
      logic [11:0] pv;
      pv = 12'(i);
      @(negedge clk);
      if (glitch_at > 0 && i == glitch_at)
        check("len_after_glitch", int'(o_len), prev_len);
      pix_ce = 1'b1;
      r = pv[3:0];
      g = pv[7:4];
      b = pv[11:8];
      hblank = (i >= 320);
      if (i == npix - 1 || i == glitch_at - 1) begin
        hsyncn = 1'b0;
        if (i == npix - 1) swap_cyc = cyc + 1;
      end
      @(negedge clk);
      pix_ce = 1'b0;
      @(negedge clk);
      hsyncn = 1'b1;
      if (i == rst_at) begin
        rst = 1'b1;
        rst_cyc = cyc + 1;
      end
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
        check("rst_mid_hblank", int'(o_hblank), 1);
        check("rst_mid_ce", int'(o_ce), 0);
        check("rst_mid_rgb", int'({o_r, o_g, o_b}), 0);
        check("rst_mid_len", int'(o_len), 0);
      end
    end
  endtask

  task automatic check_pulse(input int k, input int j, input int idx, input int base);
    int p;
    int hs;
    p  = j % lens[k];
    hs = (p < 46) ? 0 : 1;
    check($sformatf("seg%0d_cyc[%0d]", k, j), pq[idx].cyc, base + 2 * j);
    check($sformatf("seg%0d_col[%0d]", k, j), pq[idx].col, colour(exp_pix(k, p)));
    check($sformatf("seg%0d_syn[%0d]", k, j), pq[idx].syn,
          hs * 4 + int'(vs_l[k]) * 2 + int'(vb_l[k]));
  endtask

  initial begin
    int idx;
    int cnt;
    int nexp;
    int start;
    rst = 1'b1; pix_ce = 1'b0; r = '0; g = '0; b = '0;
    hblank = 1'b0; vblank = 1'b0; hsyncn = 1'b1; vsyncn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hblank", int'(o_hblank), 1);
    check("rst_vblank", int'(o_vblank), 1);
    check("rst_hsyncn", int'(o_hsyncn), 1);
    check("rst_vsyncn", int'(o_vsyncn), 1);
    check("rst_ce", int'(o_ce), 0);
    check("rst_rgb", int'({o_r, o_g, o_b}), 0);
    check("rst_len", int'(o_len), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_line(384, 0, -1, vs_l[0], vb_l[0], 0, s[0]);
    check("len_l0", int'(o_len), 384);
    run_line(384, 0, -1, vs_l[1], vb_l[1], 384, s[1]);
    check("len_l1", int'(o_len), 384);
    run_line(384, 0, -1, vs_l[2], vb_l[2], 384, s[2]);
    run_line(384, 10, -1, vs_l[3], vb_l[3], 384, s[3]);
    check("len_l3", int'(o_len), 374);
    run_line(600, 0, -1, vs_l[4], vb_l[4], 374, s[4]);
    check("len_l4_sat", int'(o_len), 512);
    run_line(384, 0, -1, vs_l[5], vb_l[5], 512, s[5]);
    run_line(384, 0, 200, vs_l[6], vb_l[6], 384, s[6]);
    check("len_l6", int'(o_len), 183);
    repeat (10) @(negedge clk);

    idx = 0;
    cnt = 0;
    while (idx < pq.size() && pq[idx].cyc < s[0] + 2) begin idx++; cnt++; end
    check("pre_swap_pulses", cnt, 0);

    for (int k = 0; k < 6; k++) begin
      int lim;
      if (k < 5) begin
        lim  = s[k+1] + 2;
        nexp = (2 * lens[k] < (s[k+1] - s[k]) / 2) ? 2 * lens[k] : (s[k+1] - s[k]) / 2;
      end else begin
        lim  = rst_cyc;
        nexp = (rst_cyc - 1 - (s[5] + 2)) / 2 + 1;
      end
      start = idx;
      cnt = 0;
      while (idx < pq.size() && pq[idx].cyc < lim) begin idx++; cnt++; end
      check($sformatf("seg%0d_count", k), cnt, nexp);
      for (int j = 0; j < cnt && j < nexp; j++)
        check_pulse(k, j, start + j, s[k] + 2);
    end

    cnt = 0;
    while (idx < pq.size() && pq[idx].cyc < s[6] + 2) begin idx++; cnt++; end
    check("post_reset_quiet", cnt, 0);
    if (idx < pq.size())
      check_pulse(6, 0, idx, s[6] + 2);
    else
      check("post_reset_first_pulse_present", 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dkong_scandoubler.md
Name: dkong_scandoubler

Overview:
- Sits directly downstream of the arcade top level and consumes its 15 kHz video: 4-bit R/G/B, H/V blank and active-low H/V sync.
- Re-emits every input line twice at double pixel rate for VGA-class monitors (31 kHz), using a ping-pong pair of line buffers.
- The frame's vertical timing is unchanged; only horizontal timing is doubled.

Parameters:
- ADDR_W, 9, line-buffer address width; 2^ADDR_W pixels per line max (input line is 384 pixels).
- PIX_DIV, 4, clock cycles per input pixel (6.144 MHz from 24.576 MHz); must be even, ≥2.
- OUT_HS_W, 46, output hsync width in output pixels.
- MIN_LINE, 16, input line lengths below this are rejected as glitches.

Ports:
- I_CLK_24576M  in  1  system clock; all logic on rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_PIX_CE  in  1  one-cycle pulse per input pixel (period PIX_DIV clocks).
- I_R / I_G / I_B  in  4 each  input colour, sampled on I_PIX_CE.
- I_HBLANK  in  1  input horizontal blank, active-high.
- I_VBLANK  in  1  input vertical blank, active-high.
- I_HSYNCn  in  1  input hsync, active-low.
- I_VSYNCn  in  1  input vsync, active-low.
- O_PIX_CE  out  1  one-cycle pulse per output pixel (period PIX_DIV/2).
- O_R / O_G / O_B  out  4 each  output colour.
- O_HBLANK  out  1  output horizontal blank.
- O_VBLANK  out  1  output vertical blank.
- O_HSYNCn  out  1  output hsync.
- O_VSYNCn  out  1  output vsync.
- O_LINE_LEN  out  ADDR_W+1  last accepted input line length, for debug.

Behaviour:
- Reset values: O_R/G/B = 0; O_HBLANK = 1; O_VBLANK = 1; O_HSYNCn = 1; O_VSYNCn = 1; O_PIX_CE = 0; O_LINE_LEN = 0. Write pointer and read state are cleared; the buffer-valid flag is cleared.
- Reset asserted mid-line has the same effect. Buffer contents are not cleared.
- Write side:
  - On I_PIX_CE, store {HBLANK, R, G, B} (13 bits) at wptr in the write bank, then increment wptr.
  - At wptr = 2^ADDR_W-1, stop incrementing: the last entry is overwritten and the count saturates.
- Line boundary = falling edge of I_HSYNCn, detected against a registered copy.
  - Count ≥ MIN_LINE: latch the count into line_len and O_LINE_LEN, swap banks, set valid, reset wptr to 0, and latch I_VSYNCn/I_VBLANK into the next-line sync regs.
  - Count < MIN_LINE: reset wptr only; no swap, no latch.
- Read side states: IDLE, PASS0, PASS1.
  - A bank swap from any state enters PASS0 with hcnt = 0 and the phase counter cleared.
  - An output tick occurs every PIX_DIV/2 clocks while in PASS0/PASS1.
  - On each tick: read the read bank at hcnt; when hcnt = line_len-1, set hcnt = 0 and go PASS0→PASS1 or PASS1→IDLE; otherwise hcnt++.
  - A swap arriving during PASS1 (short or jittered line) restarts PASS0 immediately; the truncated pass is not completed.
- Output pipeline: synchronous RAM read (1 clock) plus an output register. O_PIX_CE and the O_R/G/B/O_HBLANK update occur together, 2 clocks after the tick.
- O_HSYNCn = 0 while hcnt < OUT_HS_W within each pass, delayed through the same 2-clock pipeline.
- O_VSYNCn / O_VBLANK are the values latched at the swap, held for both passes (one input-line delay, matching the buffer delay).
- IDLE or valid = 0: outputs black, O_HBLANK = 1, O_HSYNCn = 1.
- Simultaneous I_PIX_CE and hsync fall: the pixel is written first (it counts toward the length), then the swap occurs.
- The RAM is dual-port: write bank and read bank are always different, so there is no read/write collision.

Test Plan:
- Reset, then 384-pixel lines (hsync fall every 1536 clocks) → O_LINE_LEN = 384; after the first swap each input line yields 2×384 O_PIX_CE pulses, each pass 768 clocks.
- Ramp R = pixel[3:0] on line N → on line N+1, both passes emit R = 0,1,…,15,0,…; the first O_PIX_CE occurs 2 clocks after the swap.
- Hsync pulse after 10 pixels → rejected: no swap, O_LINE_LEN unchanged, output continues the current line.
- 600-pixel line with ADDR_W = 9 → O_LINE_LEN = 512; entry 511 holds pixel 599.
- Drive I_VSYNCn low on input line K → O_VSYNCn low during both passes of line K+1 only; O_HSYNCn low for the first 46 output pixels of each pass.
- Assert I_RESET mid-PASS1 → next clock shows O_HBLANK = 1, O_PIX_CE = 0, RGB = 0; no output until the next accepted line completes.
